// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encodings, phase codes and light decode for the intersection scheduler
package traffic_pkg;

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;

    typedef enum logic [2:0] {
        PH_MG  = 3'd0,
        PH_MY  = 3'd1,
        PH_AR1 = 3'd2,
        PH_SG  = 3'd3,
        PH_SY  = 3'd4,
        PH_AR2 = 3'd5,
        PH_PW  = 3'd6
    } phase_e;

    // Returns {main, side}; anything unrecognised shows red both ways.
    function automatic logic [5:0] light_of(input phase_e p);
        logic [5:0] r;
        case (p)
            PH_MG:   r = {LT_GREEN,  LT_RED};
            PH_MY:   r = {LT_YELLOW, LT_RED};
            PH_SG:   r = {LT_RED,    LT_GREEN};
            PH_SY:   r = {LT_RED,    LT_YELLOW};
            default: r = {LT_RED,    LT_RED};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - saturating tick counter measuring time spent in the current phase
module phase_timer #(
    parameter int TMR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick,
    output logic [TMR_W-1:0] count
);

    // Clear wins over tick so a fresh phase always starts from zero; hold at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (tick && (count != {TMR_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - intersection phase sequencer with request latching and emergency preemption
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TMR_W      = 4,
    parameter int MIN_GREEN  = 7,
    parameter int SIDE_GREEN = 5,
    parameter int YELLOW     = 2,
    parameter int ALL_RED    = 1,
    parameter int PED_WALK   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       emerg_req,
    output logic [2:0] light_main,
    output logic [2:0] light_side,
    output logic       walk,
    output logic       side_ack,
    output logic       ped_ack,
    output logic       emerg_active,
    output logic [2:0] phase
);

    // Timer value on the final tick of each timed phase.
    localparam logic [TMR_W-1:0] MG_LAST = TMR_W'(MIN_GREEN - 1);
    localparam logic [TMR_W-1:0] SG_LAST = TMR_W'(SIDE_GREEN - 1);
    localparam logic [TMR_W-1:0] Y_LAST  = TMR_W'(YELLOW - 1);
    localparam logic [TMR_W-1:0] AR_LAST = TMR_W'(ALL_RED - 1);
    localparam logic [TMR_W-1:0] PW_LAST = TMR_W'(PED_WALK - 1);

    phase_e           state_q;
    phase_e           state_d;
    logic [TMR_W-1:0] timer;
    logic             timer_clr;
    logic             side_pend;
    logic             ped_pend;
    logic             from_ped;
    logic             fresh;
    logic             enter_sg;
    logic             enter_pw;
    logic             enter_ar2;

    phase_timer #(.TMR_W(TMR_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .tick  (tick),
        .count (timer)
    );

    assign timer_clr = (state_d != state_q);
    assign enter_sg  = (state_d == PH_SG)  && (state_q != PH_SG);
    assign enter_pw  = (state_d == PH_PW)  && (state_q != PH_PW);
    assign enter_ar2 = (state_d == PH_AR2) && (state_q != PH_AR2);

    // Next-phase selection; every exit except the emergency aborts waits for a tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_MG: begin
                if (tick && (timer >= MG_LAST) && (side_pend || ped_pend) && !emerg_req)
                    state_d = PH_MY;
            end
            PH_MY: begin
                if (tick && (timer == Y_LAST))
                    state_d = PH_AR1;
            end
            PH_AR1: begin
                if (tick && (timer == AR_LAST)) begin
                    if (emerg_req)      state_d = PH_MG;
                    else if (ped_pend)  state_d = PH_PW;
                    else if (side_pend) state_d = PH_SG;
                    else                state_d = PH_MG;
                end
            end
            PH_SG: begin
                if (emerg_req || (tick && (timer == SG_LAST)))
                    state_d = PH_SY;
            end
            PH_SY: begin
                if (tick && (timer == Y_LAST))
                    state_d = PH_AR2;
            end
            PH_PW: begin
                if (emerg_req || (tick && (timer == PW_LAST)))
                    state_d = PH_AR2;
            end
            PH_AR2: begin
                // Side may only follow a walk, so two side greens are always split by main green.
                if (tick && (timer == AR_LAST)) begin
                    if (emerg_req)                   state_d = PH_MG;
                    else if (from_ped && side_pend)  state_d = PH_SG;
                    else                             state_d = PH_MG;
                end
            end
            default: state_d = PH_MG;
        endcase
    end

    // Phase register plus request latches; a clear on service entry beats a same-edge request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PH_MG;
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
            from_ped  <= 1'b0;
            fresh     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fresh     <= timer_clr;
            side_pend <= enter_sg ? 1'b0 : (side_pend | side_req);
            ped_pend  <= enter_pw ? 1'b0 : (ped_pend | ped_req);
            if (enter_ar2)
                from_ped <= (state_q == PH_PW);
        end
    end

    // Outputs decode the registered phase only, so they change together with it.
    always_comb begin
        {light_main, light_side} = light_of(state_q);
        walk         = (state_q == PH_PW);
        side_ack     = fresh && (state_q == PH_SG);
        ped_ack      = fresh && (state_q == PH_PW);
        emerg_active = emerg_req && (state_q == PH_MG);
        phase        = state_q;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed self-checking bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg_req = 1'b0;
    logic [2:0] light_main;
    logic [2:0] light_side;
    logic       walk;
    logic       side_ack;
    logic       ped_ack;
    logic       emerg_active;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_phase_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .side_req     (side_req),
        .ped_req      (ped_req),
        .emerg_req    (emerg_req),
        .light_main   (light_main),
        .light_side   (light_side),
        .walk         (walk),
        .side_ack     (side_ack),
        .ped_ack      (ped_ack),
        .emerg_active (emerg_active),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected phase code per test and cycle (cycle 0 = first MG cycle after reset).
    function automatic int exp_phase(input int t, input int c);
        int p;
        p = 0;
        case (t)
            2: begin
                if (c <= 6) p = 0; else if (c <= 8) p = 1; else if (c == 9) p = 2;
                else if (c <= 14) p = 3; else if (c <= 16) p = 4; else if (c == 17) p = 5;
                else p = 0;
            end
            3: begin
                if (c <= 6) p = 0; else if (c <= 8) p = 1; else if (c == 9) p = 2;
                else if (c <= 12) p = 6; else if (c == 13) p = 5; else if (c <= 18) p = 3;
                else if (c <= 20) p = 4; else if (c == 21) p = 5; else p = 0;
            end
            4: begin
                if (c <= 6) p = 0; else if (c <= 8) p = 1; else if (c == 9) p = 2;
                else if (c <= 11) p = 3; else if (c <= 13) p = 4; else if (c == 14) p = 5;
                else if (c <= 31) p = 0; else if (c <= 33) p = 1; else if (c == 34) p = 2;
                else p = 3;
            end
            5: begin
                if (c <= 24) p = 0; else if (c <= 32) p = 1; else if (c <= 36) p = 2;
                else if (c <= 56) p = 3; else if (c <= 64) p = 4; else if (c <= 68) p = 5;
                else p = 0;
            end
            6: begin
                if (c <= 6) p = 0; else if (c <= 8) p = 1; else if (c == 9) p = 2;
                else if (c <= 11) p = 6; else p = 0;
            end
            default: p = 0;
        endcase
        return p;
    endfunction

    function automatic int exp_main(input int p);
        case (p)
            0: return 1;
            1: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_side(input int p);
        case (p)
            3: return 1;
            4: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_side_ack(input int t, input int c);
        case (t)
            2: return int'(c == 10);
            3: return int'(c == 14);
            4: return int'(c == 10 || c == 35);
            5: return int'(c == 37);
            default: return 0;
        endcase
    endfunction

    function automatic int exp_ped_ack(input int t, input int c);
        return int'((t == 3 || t == 6) && c == 10);
    endfunction

    function automatic int exp_emerg(input int t, input int c);
        return int'(t == 4 && c >= 15 && c <= 30);
    endfunction

    task automatic drive(input int t, input int c);
        tick      = (t == 5) ? (c % 4 == 0) : 1'b1;
        side_req  = ((t == 2 || t == 4) && c == 2) || ((t == 3 || t == 6) && c == 1)
                    || (t == 4 && c == 20) || (t == 5 && c == 1);
        ped_req   = (t == 3 || t == 6) && c == 1;
        emerg_req = (t == 4) && c >= 11 && c <= 30;
        rst       = (t == 6) && c == 11;
    endtask

    task automatic check_cycle(input int t, input int c);
        int p;
        p = exp_phase(t, c);
        check($sformatf("t%0d c%0d phase", t, c), int'(phase), p);
        check($sformatf("t%0d c%0d main", t, c), int'(light_main), exp_main(p));
        check($sformatf("t%0d c%0d side", t, c), int'(light_side), exp_side(p));
        check($sformatf("t%0d c%0d walk", t, c), int'(walk), int'(p == 6));
        check($sformatf("t%0d c%0d side_ack", t, c), int'(side_ack), exp_side_ack(t, c));
        check($sformatf("t%0d c%0d ped_ack", t, c), int'(ped_ack), exp_ped_ack(t, c));
        check($sformatf("t%0d c%0d emerg_active", t, c), int'(emerg_active), exp_emerg(t, c));
    endtask

    task automatic do_reset(input int t);
        rst = 1'b1; tick = 1'b1; side_req = 1'b0; ped_req = 1'b0; emerg_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check($sformatf("t%0d reset phase", t), int'(phase), 0);
        check($sformatf("t%0d reset main", t), int'(light_main), 1);
        check($sformatf("t%0d reset side", t), int'(light_side), 4);
        check($sformatf("t%0d reset walk", t), int'(walk), 0);
        check($sformatf("t%0d reset acks", t), int'({side_ack, ped_ack}), 0);
    endtask

    task automatic run_test(input int t, input int ncyc);
        do_reset(t);
        for (int c = 0; c < ncyc; c++) begin
            drive(t, c);
            #2;
            check_cycle(t, c);
            @(posedge clk); #1;
        end
        rst = 1'b0; side_req = 1'b0; ped_req = 1'b0; emerg_req = 1'b0;
    endtask

    initial begin
        run_test(1, 40);
        run_test(2, 25);
        run_test(3, 28);
        run_test(4, 36);
        run_test(5, 76);
        run_test(6, 43);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
